mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single CPU<->memory port between two requesters: instruction fetch (M0) and the
//  data access of the memory stage (M1). It holds one outstanding transaction at a time. It
//  arbitrates with data priority plus anti-starvation for fetch, and registers all
//  memory-side outputs. A timeout returns an error response to the requester for the
//  load/store/inst access-fault path.
// PARAMETERS
//  XLEN        32  address/data width
//  MAX_STARVE  4   consecutive M1 grants (with M0 pending) before M0 is forced to win
//  TIMEOUT     64  cycles in BUSY without i_mem_ack before error response (>=2)
// PORTS
//  i_clk          in   1     clock, all state on rising edge
//  i_rst          in   1     reset, asynchronous, active-low
//  i_m0_req       in   1     fetch request; held high until o_m0_ack
//  i_m0_addr      in   XLEN  fetch address (read only)
//  o_m0_ack       out  1     one-cycle response pulse to fetch
//  o_m0_rdata     out  XLEN  fetch read data, valid with o_m0_ack
//  o_m0_err       out  1     fetch timeout error, valid with o_m0_ack
//  i_m1_req       in   1     data request; held high, fields stable, until o_m1_ack
//  i_m1_we        in   1     1 = store, 0 = load
//  i_m1_addr      in   XLEN  data address
//  i_m1_wdata     in   XLEN  store data
//  i_m1_be        in   4     store byte enables (ignored on load)
//  o_m1_ack       out  1     one-cycle response pulse to data side
//  o_m1_rdata     out  XLEN  load data, valid with o_m1_ack
//  o_m1_err       out  1     data timeout error, valid with o_m1_ack
//  o_mem_req      out  1     memory request, held until i_mem_ack or timeout
//  o_mem_we       out  1     memory write enable
//  o_mem_addr     out  XLEN  memory address
//  o_mem_wdata    out  XLEN  memory write data
//  o_mem_be       out  4     memory byte enables (4'hF on reads)
//  i_mem_ack      in   1     memory completion, one cycle; ignored outside BUSY
//  i_mem_rdata    in   XLEN  memory read data, valid with i_mem_ack
// BEHAVIOUR
//  Reset (i_rst=0, async): state=IDLE, starve_cnt=0, tmo_cnt=0, owner=0. All outputs are 0.
//   Reset mid-transaction abandons it; no ack is ever issued for it.
//  FSM states: IDLE, BUSY, RESP. All outputs are registered.
//  IDLE: if i_m0_req|i_m1_req, select a winner and latch its fields into o_mem_*. Set
//   o_mem_req=1, owner=winner, tmo_cnt=0, and go to BUSY. Otherwise stay in IDLE.
//   Grant rule: only one requester -> that one. Both requesting -> M1, unless
//    starve_cnt==MAX_STARVE, in which case M0 wins.
//   starve_cnt: +1 on an M1 grant while i_m0_req=1; cleared on an M0 grant; saturates at
//    MAX_STARVE.
//   M0 grants drive o_mem_we=0, o_mem_be=4'hF, o_mem_wdata=0.
//  BUSY: o_mem_* held constant; tmo_cnt increments each cycle.
//   i_mem_ack=1 -> o_mem_req=0, o_m<owner>_rdata<=i_mem_rdata, err<=0, go to RESP.
//   If instead tmo_cnt==TIMEOUT-1 -> o_mem_req=0, rdata<=0, err<=1, go to RESP.
//   Ack and timeout in the same cycle: ack wins, err=0.
//  RESP: o_m<owner>_ack=1 for exactly this cycle; then unconditionally go to IDLE.
//   rdata/err hold their values until the next response. The other master's ack stays 0.
//  Latency: request seen at edge N -> o_mem_req high after edge N+1. i_mem_ack at edge M
//   -> o_mX_ack high for cycle after edge M+1. Minimum request-to-ack is 3 cycles.
//   The next grant is no earlier than the cycle after RESP.
//  Masters must drop req the cycle after their ack. A req still high in IDLE is treated
//   as a new request.
//  Requests arriving in BUSY/RESP wait; the arbiter does not capture them early.
//  Stores: o_mX_rdata on a store ack = i_mem_rdata (don't care to masters).
// TESTING
//  1 M0 only, addr=0x100, mem acks 2 cycles after o_mem_req with 0xDEADBEEF ->
//    o_m0_ack one pulse, o_m0_rdata=0xDEADBEEF, o_m0_err=0, o_m1_ack never.
//  2 M0 and M1 request in the same cycle (M1 store 0x200, wdata 0x55, be 4'b0001) ->
//    M1 granted first with o_mem_we=1, be=4'b0001; M0 granted in the next IDLE.
//  3 M0 held high, M1 re-requests continuously, MAX_STARVE=4 -> grant sequence is
//    M1,M1,M1,M1,M0, then starve_cnt=0.
//  4 M1 load, memory never acks, TIMEOUT=64 -> o_mem_req drops after 64 BUSY cycles,
//    o_m1_ack=1, o_m1_err=1, o_m1_rdata=0.
//  5 i_mem_ack asserted exactly in the timeout cycle -> err=0, rdata=i_mem_rdata.
//    A stray i_mem_ack in IDLE -> no ack to either master.
//  6 i_rst pulled low while in BUSY -> o_mem_req=0 immediately. After release, no ack
//    is issued for the abandoned transaction, and a fresh M0 request completes normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Purpose:
//   Shares one CPU<->memory port between instruction fetch (M0) and the
//   data access of the memory stage (M1). One transaction is outstanding
//   at a time. Data has priority, except that fetch is forced to win after
//   MAX_STARVE consecutive data grants taken while fetch was waiting. A
//   transaction the memory never acknowledges is closed after TIMEOUT busy
//   cycles with an error response to its owner.
//
// Ports:
//   i_clk, i_rst           clock (rising edge), async active-low reset
//   i_m0_req/addr          fetch request (always a read)
//   o_m0_ack/rdata/err     fetch response; ack is a one-cycle pulse
//   i_m1_req/we/addr/
//     wdata/be             data request (load or store)
//   o_m1_ack/rdata/err     data response; ack is a one-cycle pulse
//   o_mem_req/we/addr/
//     wdata/be             registered memory-side request
//   i_mem_ack/rdata        memory completion and read data
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int XLEN       = 32,
  parameter int MAX_STARVE = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_m0_req,
  input  logic [XLEN-1:0] i_m0_addr,
  output logic            o_m0_ack,
  output logic [XLEN-1:0] o_m0_rdata,
  output logic            o_m0_err,
  input  logic            i_m1_req,
  input  logic            i_m1_we,
  input  logic [XLEN-1:0] i_m1_addr,
  input  logic [XLEN-1:0] i_m1_wdata,
  input  logic [3:0]      i_m1_be,
  output logic            o_m1_ack,
  output logic [XLEN-1:0] o_m1_rdata,
  output logic            o_m1_err,
  output logic            o_mem_req,
  output logic            o_mem_we,
  output logic [XLEN-1:0] o_mem_addr,
  output logic [XLEN-1:0] o_mem_wdata,
  output logic [3:0]      o_mem_be,
  input  logic            i_mem_ack,
  input  logic [XLEN-1:0] i_mem_rdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam int SW = $clog2(MAX_STARVE + 1);
  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  localparam logic [SW-1:0] STARVE_MAX = SW'(MAX_STARVE);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);

  logic [1:0]    r_state;
  logic [SW-1:0] r_starve_cnt;
  logic [TW-1:0] r_tmo_cnt;
  logic          r_owner;

  logic w_any_req;
  logic w_grant_m1;
  logic w_starved;
  logic w_timeout;
  logic w_done;

  assign w_any_req  = i_m0_req | i_m1_req;
  // Fetch only overrides data when both are asking and fetch has been
  // passed over MAX_STARVE times in a row.
  assign w_starved  = i_m0_req & (r_starve_cnt == STARVE_MAX);
  assign w_grant_m1 = i_m1_req & ~w_starved;
  assign w_timeout  = (r_tmo_cnt == TMO_LAST);
  // A memory ack in the last busy cycle still counts as a good completion.
  assign w_done     = i_mem_ack | w_timeout;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state      <= S_IDLE;
      r_starve_cnt <= '0;
      r_tmo_cnt    <= '0;
      r_owner      <= 1'b0;
      o_m0_ack     <= 1'b0;
      o_m0_rdata   <= '0;
      o_m0_err     <= 1'b0;
      o_m1_ack     <= 1'b0;
      o_m1_rdata   <= '0;
      o_m1_err     <= 1'b0;
      o_mem_req    <= 1'b0;
      o_mem_we     <= 1'b0;
      o_mem_addr   <= '0;
      o_mem_wdata  <= '0;
      o_mem_be     <= 4'h0;
    end else begin
      // Acks are single-cycle pulses raised only on entry to RESP.
      o_m0_ack <= 1'b0;
      o_m1_ack <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_state   <= S_BUSY;
            o_mem_req <= 1'b1;
            r_tmo_cnt <= '0;
            r_owner   <= w_grant_m1;
            if (w_grant_m1) begin
              o_mem_we    <= i_m1_we;
              o_mem_addr  <= i_m1_addr;
              o_mem_wdata <= i_m1_wdata;
              o_mem_be    <= i_m1_we ? i_m1_be : 4'hF;
              // Only data grants taken while fetch waits count as starvation.
              if (i_m0_req && (r_starve_cnt != STARVE_MAX)) begin
                r_starve_cnt <= r_starve_cnt + 1'b1;
              end
            end else begin
              o_mem_we     <= 1'b0;
              o_mem_addr   <= i_m0_addr;
              o_mem_wdata  <= '0;
              o_mem_be     <= 4'hF;
              r_starve_cnt <= '0;
            end
          end
        end

        S_BUSY: begin
          r_tmo_cnt <= r_tmo_cnt + 1'b1;
          if (w_done) begin
            o_mem_req <= 1'b0;
            r_state   <= S_RESP;
            if (r_owner) begin
              o_m1_ack   <= 1'b1;
              o_m1_rdata <= i_mem_ack ? i_mem_rdata : '0;
              o_m1_err   <= ~i_mem_ack;
            end else begin
              o_m0_ack   <= 1'b1;
              o_m0_rdata <= i_mem_ack ? i_mem_rdata : '0;
              o_m0_err   <= ~i_mem_ack;
            end
          end
        end

        S_RESP: begin
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
